// File: rtl/adc_lvds_tx.sv
// adc_lvds_tx: loopback / bring-up transmitter for a two-lane LVDS ADC link.
// Each CE cycle one 16-bit sample is chosen from a small input FIFO or an
// internal pattern source. It is split into two 8-bit lane words and sent out
// with the FCO frame word. A programmable bit-slip delays all three lanes.
//
// Ports
//   CLKDIV        divided link clock (sole clock)
//   RST           synchronous active-high reset
//   CE            transmit enable; low freezes the transmit pipeline
//   mode          0 FIFO, 1 ramp, 2 PATTERN, 3 PATTERN/~PATTERN alternating
//   sample_i      sample data, written when sample_valid && sample_ready
//   sample_valid  sample_i valid
//   sample_ready  FIFO not full
//   slip_amt      injected bit delay 0..7
//   slip_load     latch slip_amt
//   d0_o, d1_o    lane words, bit 7 serialized first
//   fco_o         frame word
//   underrun      output word came from an empty FIFO in mode 0

module adc_lvds_tx #(
    parameter int          RES        = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] PATTERN    = 16'hA55A,
    parameter logic [7:0]  FCO_WORD   = 8'hF0
) (
    input  logic        CLKDIV,
    input  logic        RST,
    input  logic        CE,
    input  logic [1:0]  mode,
    input  logic [15:0] sample_i,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [2:0]  slip_amt,
    input  logic        slip_load,
    output logic [7:0]  d0_o,
    output logic [7:0]  d1_o,
    output logic [7:0]  fco_o,
    output logic        underrun
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] RES_MASK  = (RES == 14) ? 16'hFFFC : 16'hFFFF;
    localparam logic [15:0] RAMP_STEP = (RES == 14) ? 16'd4 : 16'd1;

    // ---------------- input FIFO ----------------
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign sample_ready = !w_full;
    // Pop decision uses the pre-push count, so a word pushed into an empty
    // FIFO is only readable on the following cycle.
    assign w_push       = sample_valid && !w_full;
    assign w_pop        = CE && (mode == 2'd0) && !w_empty;

    always_ff @(posedge CLKDIV) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_i;
        end
    end

    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    // ---------------- source select and lane split ----------------
    logic [15:0] r_ramp;
    logic        r_alt;
    logic [15:0] w_src;
    logic [15:0] w_src_m;
    logic        w_und;
    logic [7:0]  w_lane0;
    logic [7:0]  w_lane1;

    always_comb begin
        w_src = '0;
        w_und = 1'b0;
        case (mode)
            2'd0: begin
                if (w_empty) w_und = 1'b1;
                else         w_src = r_mem[r_rd_ptr];
            end
            2'd1:    w_src = r_ramp;
            2'd2:    w_src = PATTERN;
            default: w_src = r_alt ? ~PATTERN : PATTERN;
        endcase
    end

    assign w_src_m = w_src & RES_MASK;

    always_comb begin
        w_lane0 = '0;
        w_lane1 = '0;
        for (int i = 0; i < 8; i++) begin
            w_lane1[i] = w_src_m[15 - 2*i];
            w_lane0[i] = w_src_m[14 - 2*i];
        end
    end

    // ---------------- two-stage pipeline with bit-slip ----------------
    logic [7:0]  r_c0, r_c1, r_cf;
    logic [7:0]  r_p0, r_p1, r_pf;
    logic        r_und1;
    logic [2:0]  r_k;
    logic [7:0]  r_d0, r_d1, r_fco;
    logic        r_und;
    logic [15:0] w_cat0, w_cat1, w_catf;

    // The low byte of {prev, cur} >> k is the serial stream delayed by k bits.
    assign w_cat0 = {r_p0, r_c0} >> r_k;
    assign w_cat1 = {r_p1, r_c1} >> r_k;
    assign w_catf = {r_pf, r_cf} >> r_k;

    always_ff @(posedge CLKDIV) begin
        if (RST) begin
            r_ramp <= '0;
            r_alt  <= 1'b0;
            r_k    <= '0;
            r_c0   <= '0;
            r_c1   <= '0;
            r_cf   <= '0;
            r_p0   <= '0;
            r_p1   <= '0;
            r_pf   <= '0;
            r_und1 <= 1'b0;
            r_d0   <= '0;
            r_d1   <= '0;
            r_fco  <= '0;
            r_und  <= 1'b0;
        end else begin
            if (slip_load) r_k <= slip_amt;
            if (CE) begin
                // Ramp and alternate phase run on every CE cycle, whatever
                // the mode, so they act as free-running stream references.
                r_ramp <= r_ramp + RAMP_STEP;
                r_alt  <= ~r_alt;
                r_p0   <= r_c0;
                r_p1   <= r_c1;
                r_pf   <= r_cf;
                r_c0   <= w_lane0;
                r_c1   <= w_lane1;
                r_cf   <= FCO_WORD;
                r_und1 <= w_und;
                r_d0   <= w_cat0[7:0];
                r_d1   <= w_cat1[7:0];
                r_fco  <= w_catf[7:0];
                r_und  <= r_und1;
            end
        end
    end

    assign d0_o     = r_d0;
    assign d1_o     = r_d1;
    assign fco_o    = r_fco;
    assign underrun = r_und;

endmodule

// File: tb/tb_adc_lvds_tx.sv
module tb_adc_lvds_tx;

    localparam logic [15:0] PAT = 16'hA55A;
    localparam logic [7:0]  FCW = 8'hF0;

    logic        CLKDIV = 1'b0;
    logic        RST = 1'b1;
    logic        CE = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] sample_i = '0;
    logic        sample_valid = 1'b0;
    logic [2:0]  slip_amt = '0;
    logic        slip_load = 1'b0;

    logic        sample_ready, underrun;
    logic [7:0]  d0_o, d1_o, fco_o;
    logic        b_ready, b_und;
    logic [7:0]  b_d0, b_d1, b_fco;

    adc_lvds_tx #(.RES(16), .FIFO_DEPTH(4), .PATTERN(PAT), .FCO_WORD(FCW)) dut (
        .CLKDIV(CLKDIV), .RST(RST), .CE(CE), .mode(mode), .sample_i(sample_i),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .slip_amt(slip_amt), .slip_load(slip_load),
        .d0_o(d0_o), .d1_o(d1_o), .fco_o(fco_o), .underrun(underrun));

    adc_lvds_tx #(.RES(14), .FIFO_DEPTH(4), .PATTERN(PAT), .FCO_WORD(FCW)) dut14 (
        .CLKDIV(CLKDIV), .RST(RST), .CE(CE), .mode(mode), .sample_i(sample_i),
        .sample_valid(sample_valid), .sample_ready(b_ready),
        .slip_amt(slip_amt), .slip_load(slip_load),
        .d0_o(b_d0), .d1_o(b_d1), .fco_o(b_fco), .underrun(b_und));

    always #5 CLKDIV = ~CLKDIV;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Returns {lane1, lane0} for a 16-bit source word.
    function automatic logic [15:0] lanes(input logic [15:0] s);
        logic [7:0] l1, l0;
        for (int i = 0; i < 8; i++) begin
            l1[i] = s[15 - 2*i];
            l0[i] = s[14 - 2*i];
        end
        return {l1, l0};
    endfunction

    // ---------------- bit-stream reference model (RES = 16 instance) ----------------
    bit          s0[$], s1[$], sf[$];
    logic        und_hist[$];
    logic [15:0] m_fifo[$];
    int          n_upd;
    logic [2:0]  mk;
    logic [15:0] m_ramp;
    bit          m_alt;
    logic [7:0]  e_d0, e_d1, e_f;
    logic        e_und;

    task automatic model_reset();
        s0.delete(); s1.delete(); sf.delete(); und_hist.delete(); m_fifo.delete();
        for (int b = 0; b < 16; b++) begin
            s0.push_back(1'b0); s1.push_back(1'b0); sf.push_back(1'b0);
        end
        und_hist.push_back(1'b0);
        n_upd = 0; mk = '0; m_ramp = '0; m_alt = 1'b0;
        e_d0 = '0; e_d1 = '0; e_f = '0; e_und = 1'b0;
    endtask

    task automatic drive_tick(input logic rst, input logic ce, input logic [1:0] md,
                              input logic vld, input logic [15:0] din,
                              input logic sl, input logic [2:0] sa);
        RST = rst; CE = ce; mode = md; sample_valid = vld; sample_i = din;
        slip_load = sl; slip_amt = sa;
        @(posedge CLKDIV);
        #1;
    endtask

    task automatic step(input logic rst, input logic ce, input logic [1:0] md,
                        input logic vld, input logic [15:0] din,
                        input logic sl, input logic [2:0] sa);
        logic        pop_ok, push_ok, u;
        logic [15:0] s, lw;
        logic [7:0]  fw;
        int          st;
        drive_tick(rst, ce, md, vld, din, sl, sa);
        if (rst) begin
            model_reset();
        end else begin
            push_ok = vld && (m_fifo.size() < 4);
            pop_ok  = ce && (md == 2'd0) && (m_fifo.size() > 0);
            if (ce) begin
                n_upd++;
                st = 8*n_upd - int'(mk);
                for (int b = 0; b < 8; b++) begin
                    e_d1[7-b] = s1[st+b];
                    e_d0[7-b] = s0[st+b];
                    e_f[7-b]  = sf[st+b];
                end
                e_und = und_hist[n_upd-1];
                u = 1'b0;
                s = '0;
                case (md)
                    2'd0: if (pop_ok) s = m_fifo.pop_front(); else u = 1'b1;
                    2'd1: s = m_ramp;
                    2'd2: s = PAT;
                    default: s = m_alt ? ~PAT : PAT;
                endcase
                m_ramp = m_ramp + 16'd1;
                m_alt  = !m_alt;
                lw = lanes(s);
                fw = FCW;
                for (int b = 7; b >= 0; b--) begin
                    s1.push_back(lw[8+b]);
                    s0.push_back(lw[b]);
                    sf.push_back(fw[b]);
                end
                und_hist.push_back(u);
            end
            if (push_ok) m_fifo.push_back(din);
            if (sl) mk = sa;
        end
        chk("model_d0", {8'h00, d0_o}, {8'h00, e_d0});
        chk("model_d1", {8'h00, d1_o}, {8'h00, e_d1});
        chk("model_fco", {8'h00, fco_o}, {8'h00, e_f});
        chk("model_underrun", {15'h0, underrun}, {15'h0, e_und});
        chk("model_ready", {15'h0, sample_ready}, {15'h0, logic'(m_fifo.size() < 4)});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ce;
        logic        vld;
        logic [15:0] din;
        logic [7:0]  d1, d0, fco;
        logic        und, rdy;
        logic [7:0]  d1b, d0b;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 16'hC3A5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 8'h39, 8'hC9, 8'hF0, 1'b0, 1'b1, 8'h39, 8'h49};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b1, 8'h00, 8'h00};
        tbl[4] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b1, 8'h00, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 8'hF0, 1'b1, 1'b1, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 8'hFF, 8'hFF, 8'hF0, 1'b0, 1'b1, 8'h7F, 8'h7F};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 8'hFF, 8'hFF, 8'hF0, 1'b0, 1'b1, 8'h7F, 8'h7F};

        // Reset state
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("rst_ready14", {15'h0, b_ready}, 16'h1);

        // Lane split, both resolutions
        foreach (tbl[v]) begin
            drive_tick(1'b0, tbl[v].ce, 2'd0, tbl[v].vld, tbl[v].din, 1'b0, 3'd0);
            chk($sformatf("tbl%0d_d1", v), {8'h00, d1_o}, {8'h00, tbl[v].d1});
            chk($sformatf("tbl%0d_d0", v), {8'h00, d0_o}, {8'h00, tbl[v].d0});
            chk($sformatf("tbl%0d_fco", v), {8'h00, fco_o}, {8'h00, tbl[v].fco});
            chk($sformatf("tbl%0d_und", v), {15'h0, underrun}, {15'h0, tbl[v].und});
            chk($sformatf("tbl%0d_rdy", v), {15'h0, sample_ready}, {15'h0, tbl[v].rdy});
            chk($sformatf("tbl%0d_d1_r14", v), {8'h00, b_d1}, {8'h00, tbl[v].d1b});
            chk($sformatf("tbl%0d_d0_r14", v), {8'h00, b_d0}, {8'h00, tbl[v].d0b});
            chk($sformatf("tbl%0d_fco_r14", v), {8'h00, b_fco}, {8'h00, tbl[v].fco});
            chk($sformatf("tbl%0d_und_r14", v), {15'h0, b_und}, {15'h0, tbl[v].und});
            chk($sformatf("tbl%0d_rdy_r14", v), {15'h0, b_ready}, {15'h0, tbl[v].rdy});
        end

        // FIFO full / empty
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1, 16'h1111 * i[15:0], 1'b0, 3'd0);
            chk($sformatf("fill_ready%0d", i), {15'h0, sample_ready}, (i < 4) ? 16'h1 : 16'h0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("drain_und", {15'h0, underrun}, 16'h1);
        chk("drain_d0", {8'h00, d0_o}, 16'h0);
        chk("drain_d1", {8'h00, d1_o}, 16'h0);

        // Slip: k = 1 in modes 2 and 0, then k = 3
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 2'd2, 1'b1, 16'hA1B2, 1'b1, 3'd1);
        step(1'b0, 1'b0, 2'd2, 1'b1, 16'h3C4D, 1'b0, 3'd0);
        step(1'b0, 1'b0, 2'd2, 1'b1, 16'h5E6F, 1'b0, 3'd0);
        step(1'b0, 1'b0, 2'd2, 1'b1, 16'h7081, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("slip1_fco", {8'h00, fco_o}, 16'h0078);
        step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b1, 3'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("slip3_fco", {8'h00, fco_o}, 16'h001E);

        // CE freeze in alternate mode
        step(1'b1, 1'b0, 2'd3, 1'b0, 16'h0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 1'b0, 3'd0);
            chk("gap_d1", {8'h00, d1_o}, 16'h00C3);
            chk("gap_d0", {8'h00, d0_o}, 16'h003C);
        end
        step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("resume_d1", {8'h00, d1_o}, 16'h003C);
        chk("resume_d0", {8'h00, d0_o}, 16'h00C3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 1'b0, 3'd0);

        // Ramp step for RES = 14 (RES = 16 checked by the model)
        step(1'b1, 1'b0, 2'd1, 1'b0, 16'h0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("ramp14_w2_d1", {8'h00, b_d1}, 16'h0000);
        chk("ramp14_w2_d0", {8'h00, b_d0}, 16'h0040);
        step(1'b0, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("ramp14_w3_d1", {8'h00, b_d1}, 16'h0040);
        chk("ramp14_w3_d0", {8'h00, b_d0}, 16'h0000);

        // Reset mid-operation: FIFO half full, ramp nonzero, k = 5
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 2'd1, 1'b1, 16'h1234, 1'b1, 3'd5);
        step(1'b0, 1'b1, 2'd1, 1'b1, 16'h5678, 1'b0, 3'd0);
        step(1'b1, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("midrst_fco", {8'h00, fco_o}, 16'h0);
        chk("midrst_ready", {15'h0, sample_ready}, 16'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("ramp_restart_d0", {8'h00, d0_o}, 16'h0080);
        chk("ramp_restart_d1", {8'h00, d1_o}, 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0, 3'd0);
        chk("post_rst_empty_und", {15'h0, underrun}, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
